lut_addr_gen: RTL and testbench
===============================

LUT_ADDR_GEN -- requirements
Module: lut_addr_gen

Interface
REQ-001 Parameter SEGMENT_NUM, default 14: number of segments, each twice the width of the previous one.
REQ-002 Parameter BIN_WIDTH, default 8: log2 of the bins per segment (256).
REQ-003 Parameter ADDR_WIDTH, default 12: width of the coefficient-memory address.
REQ-004 Parameter EXP_MIN, default -4: unbiased exponent of the segment-0 lower bound (2^EXP_MIN).
REQ-005 Port clock, input, 1: the single clock; all logic is on the rising edge.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port r2, input, 32: IEEE-754 single-precision squared distance.
REQ-008 Port r2_valid, input, 1: r2 is valid this cycle; there is no backpressure.
REQ-009 Port lut_address, output, ADDR_WIDTH: address to the coefficient memory.
REQ-010 Port lut_rden, output, 1: read enable to the coefficient memory.
REQ-011 Port lut_wren, output, 1: held at 0 at all times.
REQ-012 Port r2_out, output, 32: r2, delayed to align with the memory q output.
REQ-013 Port out_valid, output, 1: r2_out and q are valid this cycle.
REQ-014 Port out_underflow, output, 1: this output was clamped to address 0.
REQ-015 Port drop_cnt, output, 16: saturating count of dropped inputs.

Function
REQ-016 Decode: s = biased exponent - (127 + EXP_MIN); bin = mantissa[22:23-BIN_WIDTH]; address = s*2^BIN_WIDTH + bin.
REQ-017 Underflow (0 <= r2 < 2^EXP_MIN, including +0 and denormals): address 0, passes as valid, out_underflow=1.
REQ-018 Drop (s >= SEGMENT_NUM, sign bit set, Inf, NaN): no lut_rden, no out_valid, drop_cnt += 1.
REQ-019 Pipeline stage 1: r2_valid at edge N is registered and decoded.
REQ-020 Pipeline stage 2: lut_address/lut_rden are registered at edge N+1.
REQ-021 Output: r2_out/out_valid/out_underflow are registered at edge N+2, aligned with the memory's 1-cycle q latency.
REQ-022 Throughput is one input per cycle; back-to-back inputs shall produce back-to-back outputs with no bubbles.
REQ-023 lut_address holds its last value when lut_rden=0.
REQ-024 drop_cnt saturates at 16'hFFFF and never wraps.
REQ-025 Only valid inputs are decoded; r2 with r2_valid=0 has no effect on any output or counter.

Reset
REQ-026 Asserting rst_n=0 shall immediately clear all pipeline valids, lut_rden, out_valid, out_underflow, lut_address, r2_out and drop_cnt to 0.
REQ-027 Reset asserted mid-pipeline discards in-flight inputs; no stale out_valid appears after release.
REQ-028 The first input is accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-029 With macro LUT_ADDR_DROP_CNT_EN defined, the saturating drop counter is implemented.
REQ-030 Without LUT_ADDR_DROP_CNT_EN, drop_cnt is tied to 0 and no counter flops exist; dropping still suppresses lut_rden and out_valid.

Structure
REQ-031 The shared package holds the segment/bin constants, the float field positions (sign 31, exponent 30:23, mantissa 22:0) and the bias 127.
REQ-032 The float field decode and range classification shall be one combinational sub-module, lut_addr_decode; lut_addr_gen owns all registers.

Verification
REQ-033 r2=0x3F800000 (1.0) -> lut_address=1024 with lut_rden at N+1, then out_valid=1, r2_out=0x3F800000 at N+2.
REQ-034 r2=0x3FC00000 (1.5) -> address 1152; r2=0x3D800000 (0.0625) -> address 0 with out_underflow=0.
REQ-035 r2=0x3C23D70A (0.01) and r2=0x00000000 -> address 0 with out_underflow=1, out_valid=1.
REQ-036 r2=0x44800000 (1024.0), 0xBF800000 (-1.0) and 0x7FC00000 (NaN) -> no rden, no out_valid, drop_cnt=3; 65538 drops -> drop_cnt=0xFFFF.
REQ-037 Ten back-to-back valid inputs with rst_n pulsed low at the 5th cycle -> out_valid drops immediately and only inputs after release emerge.

Source files
------------

// File: rtl/lut_addr_pkg.sv
// Shared constants for the LUT address generator: IEEE-754 single field
// positions, exponent bias, default segment/bin geometry and the decode classes.
package lut_addr_pkg;

  localparam int SEGMENT_NUM_DEF = 14;
  localparam int BIN_WIDTH_DEF   = 8;
  localparam int ADDR_WIDTH_DEF  = 12;
  localparam int EXP_MIN_DEF     = -4;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int EXP_BIAS = 127;

  localparam logic [7:0]  EXP_SPECIAL  = 8'hFF;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    CLS_IN_RANGE  = 2'd0,
    CLS_UNDERFLOW = 2'd1,
    CLS_DROP      = 2'd2
  } lut_cls_t;

endpackage

// File: rtl/lut_addr_decode.sv
// Combinational float decode: splits r2 into segment/bin and classifies it as
// in range, underflow (clamped to address 0) or drop.
import lut_addr_pkg::*;

module lut_addr_decode #(
  parameter int SEGMENT_NUM = SEGMENT_NUM_DEF,
  parameter int BIN_WIDTH   = BIN_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int EXP_MIN     = EXP_MIN_DEF
) (
  input  logic [31:0]           r2,
  output lut_cls_t              cls,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic signed [9:0] SEG_BASE  = 10'(EXP_BIAS + EXP_MIN);
  localparam logic signed [9:0] SEG_LIMIT = 10'(SEGMENT_NUM);

  logic [7:0]           exp_f;
  logic [BIN_WIDTH-1:0] bin;
  logic signed [9:0]    seg;
  logic                 unused_mant;

  assign exp_f       = r2[EXP_MSB:EXP_LSB];
  assign bin         = r2[MANT_MSB -: BIN_WIDTH];
  assign unused_mant = ^r2[MANT_MSB-BIN_WIDTH:0];

  // Exponent range 0..255 minus the base always fits in 10 signed bits.
  assign seg = $signed({2'b00, exp_f}) - SEG_BASE;

  always_comb begin
    cls  = CLS_IN_RANGE;
    addr = '0;
    if (r2[SIGN_BIT] || (exp_f == EXP_SPECIAL)) begin
      cls = CLS_DROP;
    end else if (seg[9]) begin
      cls = CLS_UNDERFLOW;
    end else if (seg >= SEG_LIMIT) begin
      cls = CLS_DROP;
    end else begin
      addr = (ADDR_WIDTH'(seg) << BIN_WIDTH) | ADDR_WIDTH'(bin);
    end
  end

endmodule

// File: rtl/lut_addr_gen.sv
// Piecewise-LUT address generator for a squared-distance float, aligned with a
// 1-cycle coefficient memory. Define LUT_ADDR_DROP_CNT_EN to build the drop counter.
import lut_addr_pkg::*;

module lut_addr_gen #(
  parameter int SEGMENT_NUM = SEGMENT_NUM_DEF,
  parameter int BIN_WIDTH   = BIN_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int EXP_MIN     = EXP_MIN_DEF
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [31:0]           r2,
  input  logic                  r2_valid,
  output logic [ADDR_WIDTH-1:0] lut_address,
  output logic                  lut_rden,
  output logic                  lut_wren,
  output logic [31:0]           r2_out,
  output logic                  out_valid,
  output logic                  out_underflow,
  output logic [15:0]           drop_cnt
);

  logic                  vld_p0;
  logic [31:0]           r2_p0;
  lut_cls_t              cls_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  keep_p0;
  logic                  drop_p0;

  logic                  vld_p1;
  logic [31:0]           r2_p1;
  logic                  under_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  logic                  vld_p2;
  logic [31:0]           r2_p2;
  logic                  under_p2;

  // Stage 0: capture the incoming sample.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      r2_p0  <= '0;
    end else begin
      vld_p0 <= r2_valid;
      if (r2_valid) r2_p0 <= r2;
    end
  end

  lut_addr_decode #(
    .SEGMENT_NUM (SEGMENT_NUM),
    .BIN_WIDTH   (BIN_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .EXP_MIN     (EXP_MIN)
  ) u_decode (
    .r2   (r2_p0),
    .cls  (cls_p0),
    .addr (addr_p0)
  );

  assign keep_p0 = vld_p0 && (cls_p0 != CLS_DROP);
  assign drop_p0 = vld_p0 && (cls_p0 == CLS_DROP);

  // Stage 1: memory request; the address is only updated by accepted samples.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      r2_p1    <= '0;
      under_p1 <= 1'b0;
      addr_p1  <= '0;
    end else begin
      vld_p1   <= keep_p0;
      under_p1 <= keep_p0 && (cls_p0 == CLS_UNDERFLOW);
      if (keep_p0) begin
        r2_p1   <= r2_p0;
        addr_p1 <= addr_p0;
      end
    end
  end

  // Stage 2: output aligned with the memory's registered q.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      r2_p2    <= '0;
      under_p2 <= 1'b0;
    end else begin
      vld_p2   <= vld_p1;
      under_p2 <= under_p1;
      if (vld_p1) r2_p2 <= r2_p1;
    end
  end

`ifdef LUT_ADDR_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop_p0 && (drop_cnt_q != DROP_CNT_MAX)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop_p0;
  assign drop_cnt    = '0;
`endif

  assign lut_address   = addr_p1;
  assign lut_rden      = vld_p1;
  assign lut_wren      = 1'b0;
  assign r2_out        = r2_p2;
  assign out_valid     = vld_p2;
  assign out_underflow = under_p2;

endmodule

// File: tb/tb_lut_addr_gen.sv
// Bench for lut_addr_gen: directed and random float samples checked against a
// real-valued segment/bin model, including reset and drop-counter behaviour.
module tb_lut_addr_gen;

`ifdef LUT_ADDR_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam int EXP_MIN = -4;
  localparam int SEGS    = 14;
  localparam int BINS    = 256;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [31:0] r2;
  logic        r2_valid;
  logic [11:0] lut_address;
  logic        lut_rden;
  logic        lut_wren;
  logic [31:0] r2_out;
  logic        out_valid;
  logic        out_underflow;
  logic [15:0] drop_cnt;

  always #5 clock = ~clock;

  lut_addr_gen dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .r2            (r2),
    .r2_valid      (r2_valid),
    .lut_address   (lut_address),
    .lut_rden      (lut_rden),
    .lut_wren      (lut_wren),
    .r2_out        (r2_out),
    .out_valid     (out_valid),
    .out_underflow (out_underflow),
    .drop_cnt      (drop_cnt)
  );

  typedef struct packed {
    logic        drop;
    logic        under;
    logic [11:0] addr;
  } pred_t;

  typedef struct {
    logic        vld;
    logic [31:0] r2;
  } smp_t;

  smp_t        h0, h1, h2;
  logic [11:0] exp_addr;
  int          exp_drop;
  int          total = 0;
  int          bad = 0;

  function automatic real pow2(input int e);
    real r;
    r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  // Reference: evaluate the float as a real number, then locate its octave.
  function automatic pred_t predict(input logic [31:0] x);
    pred_t p;
    real   v;
    int    k;
    p = '0;
    if (x[31] || (x[30:23] == 8'hFF)) begin
      p.drop = 1'b1;
      return p;
    end
    if (x[30:23] == 8'd0) v = real'(x[22:0]) * pow2(-149);
    else v = (1.0 + real'(x[22:0]) / 8388608.0) * pow2(int'(x[30:23]) - 127);
    if (v < pow2(EXP_MIN)) begin
      p.under = 1'b1;
      return p;
    end
    k = EXP_MIN;
    while (v >= pow2(k + 1)) k++;
    if (k - EXP_MIN >= SEGS) begin
      p.drop = 1'b1;
      return p;
    end
    p.addr = 12'((k - EXP_MIN) * BINS + int'($floor((v / pow2(k) - 1.0) * real'(BINS))));
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    h0.vld = 1'b0; h0.r2 = '0;
    h1.vld = 1'b0; h1.r2 = '0;
    h2.vld = 1'b0; h2.r2 = '0;
    exp_addr = '0;
    exp_drop = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] x);
    pred_t p1, p2;
    @(negedge clock);
    r2_valid = v;
    r2       = x;
    @(posedge clock);
    #1;
    h2 = h1;
    h1 = h0;
    h0.vld = v;
    h0.r2  = x;
    p1 = predict(h1.r2);
    p2 = predict(h2.r2);
    if (h1.vld && !p1.drop) exp_addr = p1.addr;
    if (h1.vld && p1.drop && CNT_EN && (exp_drop < 65535)) exp_drop++;
    chk("rden", 32'(lut_rden), 32'(h1.vld && !p1.drop));
    chk("addr", 32'(lut_address), 32'(exp_addr));
    chk("out_valid", 32'(out_valid), 32'(h2.vld && !p2.drop));
    chk("underflow", 32'(out_underflow), 32'(h2.vld && p2.under));
    if (h2.vld && !p2.drop) chk("r2_out", r2_out, h2.r2);
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("wren", 32'(lut_wren), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n    = 1'b0;
    r2_valid = 1'b1;
    r2       = 32'h3F800000;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rden", 32'(lut_rden), 32'd0);
    chk("rst_addr", 32'(lut_address), 32'd0);
    chk("rst_r2_out", r2_out, 32'd0);
    chk("rst_underflow", 32'(out_underflow), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    clear_model();
    @(posedge clock);
    #1;
    chk("rst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clock);
    rst_n    = 1'b1;
    r2_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_r2();
    logic [31:0] x;
    case ($urandom_range(0, 9))
      0:       x = 32'h00000000;
      1:       x = {9'd0, 23'($urandom)};
      2:       x = {1'b1, 8'($urandom_range(100, 140)), 23'($urandom)};
      3:       x = {1'b0, 8'hFF, 23'($urandom_range(0, 1) * $urandom)};
      4:       x = {1'b0, 8'($urandom_range(136, 160)), 23'($urandom)};
      default: x = {1'b0, 8'($urandom_range(115, 137)), 23'($urandom)};
    endcase
    return x;
  endfunction

  initial begin
    clear_model();
    rst_n    = 1'b0;
    r2_valid = 1'b0;
    r2       = '0;
    #1;
    chk("init_out_valid", 32'(out_valid), 32'd0);
    chk("init_rden", 32'(lut_rden), 32'd0);
    chk("init_addr", 32'(lut_address), 32'd0);
    chk("init_drop_cnt", 32'(drop_cnt), 32'd0);
    #20;
    @(negedge clock);
    rst_n = 1'b1;

    // 1.0 -> address 1024 one cycle after capture, output one cycle later.
    step(1'b1, 32'h3F800000);
    step(1'b0, 32'h0);
    chk("one_addr", 32'(lut_address), 32'd1024);
    chk("one_rden", 32'(lut_rden), 32'd1);
    step(1'b0, 32'h0);
    chk("one_out_valid", 32'(out_valid), 32'd1);
    chk("one_r2_out", r2_out, 32'h3F800000);

    step(1'b1, 32'h3FC00000);
    step(1'b1, 32'h3D800000);
    chk("onehalf_addr", 32'(lut_address), 32'd1152);
    step(1'b1, 32'h3C23D70A);
    chk("lower_bound_addr", 32'(lut_address), 32'd0);
    step(1'b1, 32'h00000000);
    chk("lower_bound_under", 32'(out_underflow), 32'd0);
    step(1'b1, 32'h00012345);
    chk("small_under", 32'(out_underflow), 32'd1);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    // Drops after a fresh reset: counter reads 3 when built in.
    do_reset();
    step(1'b1, 32'h44800000);
    step(1'b1, 32'hBF800000);
    step(1'b1, 32'h7FC00000);
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);
    chk("drop3_cnt", 32'(drop_cnt), CNT_EN ? 32'd3 : 32'd0);
    chk("drop3_valid", 32'(out_valid), 32'd0);

    // Idle cycles with garbage on r2 must not disturb anything.
    for (int i = 0; i < 6; i++) step(1'b0, 32'(i) ^ 32'h7F800000);

    // Back-to-back run interrupted by reset on the fifth sample.
    for (int i = 1; i <= 4; i++) step(1'b1, {1'b0, 8'(124 + i), 23'(i * 4096)});
    do_reset();
    for (int i = 6; i <= 10; i++) step(1'b1, {1'b0, 8'(120 + i), 23'(i * 8192)});
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

    for (int i = 0; i < 400; i++) step(($urandom_range(0, 3) != 0), rand_r2());
    step(1'b0, 32'h0);
    step(1'b0, 32'h0);

`ifdef LUT_ADDR_DROP_CNT_EN
    repeat (65538) step(1'b1, 32'hBF800000);
    step(1'b0, 32'h0);
    chk("drop_sat", 32'(drop_cnt), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
